// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack data port, builds the MEM/WB register. Optional MEM_TIMEOUT_EN aborts hung accesses.
// Latency: 1 cycle for non-memory ops, >=2 cycles for loads/stores (ack on first BUSY cycle at the earliest).
// Backpressure: stall holds upstream while a request is outstanding; it drops combinationally in the ack/timeout cycle.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [72:0] ex_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [70:0] mem_wb,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_regwrite,
    output logic [31:0] mem_wb_data,
    output logic        mem_fault
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic        regwrite, memtoreg, memwrite, memread;
    logic [31:0] result, sdata;
    logic [4:0]  dest;
    logic        memop, illegal, busy, to_hit;

    logic [0:0]  state_q, state_d;
    logic [70:0] mem_wb_q, mem_wb_d;
    logic        req_q, req_d, we_q, we_d, fault_q, fault_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

    assign regwrite = ex_mem[72];
    assign memtoreg = ex_mem[71];
    assign memwrite = ex_mem[70];
    assign memread  = ex_mem[69];
    assign result   = ex_mem[68:37];
    assign sdata    = ex_mem[36:5];
    assign dest     = ex_mem[4:0];

    assign memop   = memread | memwrite;
    assign illegal = (memread & memwrite) | (memop & (result[1:0] != 2'b00));
    assign busy    = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    assign to_hit = busy && !dmem_ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Held at zero while idle, so every access starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (!busy) begin
            to_cnt_q <= '0;
        end else if (!dmem_ack) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_hit             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT > 0) && (TO_W > 0);
`endif

    assign stall = (!busy && memop && !illegal) || (busy && !dmem_ack && !to_hit);

    always_comb begin
        state_d  = state_q;
        mem_wb_d = '0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fault_d  = 1'b0;
        if (!busy) begin
            if (!memop) begin
                mem_wb_d = {regwrite, memtoreg, 32'h0, result, dest};
            end else if (illegal) begin
                mem_wb_d = {1'b0, memtoreg, 32'h0, result, dest};
                fault_d  = 1'b1;
            end else begin
                req_d   = 1'b1;
                we_d    = memwrite;
                addr_d  = result;
                wdata_d = sdata;
                state_d = BUSY;
            end
        end else if (dmem_ack) begin
            mem_wb_d = {regwrite, memtoreg, (memread ? dmem_rdata : 32'h0), result, dest};
            req_d    = 1'b0;
            state_d  = IDLE;
        end else if (to_hit) begin
            mem_wb_d = {1'b0, memtoreg, 32'h0, result, dest};
            req_d    = 1'b0;
            fault_d  = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mem_wb_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_wb_q <= mem_wb_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign mem_fault       = fault_q;
    assign mem_wb          = mem_wb_q;
    assign mem_wb_rd       = mem_wb_q[4:0];
    assign mem_wb_regwrite = mem_wb_q[70];
    assign mem_wb_data     = mem_wb_q[69] ? mem_wb_q[68:37] : mem_wb_q[36:5];
endmodule
